// File: rtl/fxp_div_seq_pkg.sv
// Shared definitions for the Q16.16 sequential divider: default widths,
// the controller state encoding and the saturation value.
package fxp_pkg;

   localparam int FXP_WIDTH = 32;
   localparam int FXP_FRAC  = 16;

   // All-ones value returned on divide-by-zero and on saturated overflow
   localparam logic [FXP_WIDTH-1:0] FXP_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fxp_state_t;

endpackage

// File: rtl/fxp_div_seq_if.sv
// Request/response bundle for the sequential fixed-point divider.
// The requester drives start/a/b; the divider returns busy/done and the
// registered quotient with its divide-by-zero and overflow flags.
interface fxp_div_seq_if
   import fxp_pkg::*;
#(
   parameter int WIDTH = FXP_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic             dz;
   logic             ovf;

   modport master (
      output start, a, b,
      input  busy, done, q, dz, ovf
   );

   modport slave (
      input  start, a, b,
      output busy, done, q, dz, ovf
   );

endinterface

// File: rtl/fxp_div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder and subtract the divisor if it fits.
module fxp_div_step
   import fxp_pkg::*;
#(
   parameter int WIDTH = FXP_WIDTH
) (
   input  logic [WIDTH:0]   r,
   input  logic             d_msb,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   r_next,
   output logic             q_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // Trial subtraction one bit wider than the shifted remainder, so the top
   // bit of the difference is the borrow: no borrow means the divisor fits.
   always_comb begin
      shifted = {r, d_msb};
      diff    = shifted - {2'b00, b};
      q_bit   = ~diff[WIDTH+1];
      r_next  = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential unsigned fixed-point divider, q = floor((a << FRAC) / b),
// producing one quotient bit per clock with a start/busy/done handshake.
// Build option: define FXP_DIV_SATURATE_EN to clamp an overflowing quotient
// to all ones; otherwise the quotient is truncated to WIDTH bits.
module fxp_div_seq
   import fxp_pkg::*;
#(
   parameter int WIDTH = FXP_WIDTH,
   parameter int FRAC  = FXP_FRAC
) (
   input  logic          clk,
   input  logic          rst,
   fxp_div_seq_if.slave  bus
);

   localparam int DW    = WIDTH + FRAC;
   localparam int CNT_W = $clog2(DW);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DW - 1);

   fxp_state_t state;
   fxp_state_t state_next;

   logic [DW-1:0]    dividend;
   logic [DW-1:0]    quotient;
   logic [WIDTH:0]   remainder;
   logic [WIDTH-1:0] divisor;
   logic [CNT_W-1:0] count;

   logic [WIDTH-1:0] q_reg;
   logic             dz_reg;
   logic             ovf_reg;

   logic [WIDTH:0]   remainder_next;
   logic             q_bit;
   logic [DW-1:0]    quotient_next;
   logic             last_step;
   logic             overflow;
   logic [WIDTH-1:0] result;

   fxp_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .r      (remainder),
      .d_msb  (dividend[DW-1]),
      .b      (divisor),
      .r_next (remainder_next),
      .q_bit  (q_bit)
   );

   assign last_step = (count == '0);

   // Controller state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept only from IDLE, fixed-length CALC, one DONE cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Final quotient shaping; a bit pushed off the top also means it did not fit
   always_comb begin
      quotient_next = {quotient[DW-2:0], q_bit};
      overflow      = quotient[DW-1] | (|quotient_next[DW-1:WIDTH]);
      result        = quotient_next[WIDTH-1:0];
`ifdef FXP_DIV_SATURATE_EN
      if (overflow) begin
         result = '1;
      end
`else
`endif
   end

   // Datapath: latch operands on accept, iterate in CALC, capture result on the last step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dividend  <= '0;
         quotient  <= '0;
         remainder <= '0;
         divisor   <= '0;
         count     <= '0;
         q_reg     <= '0;
         dz_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dividend  <= {bus.a, {FRAC{1'b0}}};
                  divisor   <= bus.b;
                  remainder <= '0;
                  quotient  <= '0;
                  count     <= CNT_LOAD;
               end
            end
            CALC: begin
               dividend  <= dividend << 1;
               remainder <= remainder_next;
               quotient  <= quotient_next;
               if (!last_step) begin
                  count <= count - CNT_W'(1);
               end else if (divisor == '0) begin
                  q_reg   <= '1;
                  dz_reg  <= 1'b1;
                  ovf_reg <= 1'b0;
               end else begin
                  q_reg   <= result;
                  dz_reg  <= 1'b0;
                  ovf_reg <= overflow;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy = (state == CALC);
   assign bus.done = (state == DONE);
   assign bus.q    = q_reg;
   assign bus.dz   = dz_reg;
   assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed self-checking bench for the sequential Q16.16 divider.
// Expected quotients are hand-computed; overflow expectation follows
// whether FXP_DIV_SATURATE_EN is defined for the build.
module tb_fxp_div_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fxp_div_seq_if #(.WIDTH(32)) bus ();

   fxp_div_seq #(
      .WIDTH (32),
      .FRAC  (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request from an aligned IDLE cycle and wait (bounded) for done
   task automatic applyStimulus(input string name, input logic [31:0] ai, input logic [31:0] bi,
                                output int clocks, output int busyCycles);
      bus.a     = ai;
      bus.b     = bi;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.a      = 32'hDEADBEEF;
      bus.b      = 32'h0BADF00D;
      clocks     = 1;
      busyCycles = 0;
      checkOutput({name, "_accept_busy"}, 32'(bus.busy), 32'd1);
      while (bus.done !== 1'b1 && clocks < 200) begin
         if (bus.busy === 1'b1) busyCycles++;
         @(posedge clk);
         #1;
         clocks++;
      end
      checkOutput({name, "_done_seen"}, 32'(bus.done), 32'd1);
   endtask

   // Full transaction check: latency, busy span, results, single-cycle done
   task automatic runCase(input string name, input logic [31:0] ai, input logic [31:0] bi,
                          input logic [31:0] expQ, input logic expDz, input logic expOvf);
      int clocks;
      int busyCycles;
      applyStimulus(name, ai, bi, clocks, busyCycles);
      checkOutput({name, "_latency"}, 32'(clocks), 32'd49);
      checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'd48);
      checkOutput({name, "_q"}, bus.q, expQ);
      checkOutput({name, "_dz"}, 32'(bus.dz), 32'(expDz));
      checkOutput({name, "_ovf"}, 32'(bus.ovf), 32'(expOvf));
      @(posedge clk);
      #1;
      checkOutput({name, "_done_pulse"}, 32'(bus.done), 32'd0);
      checkOutput({name, "_q_held"}, bus.q, expQ);
   endtask

   // Global bound so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] ovfExpQ;
      int doneCount;
      int doneAt;
      logic [31:0] qAtDone;

`ifdef FXP_DIV_SATURATE_EN
      ovfExpQ = 32'hFFFFFFFF;
`else
      ovfExpQ = 32'h00000000;
`endif

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Power-on reset
      #3 rst = 1'b0;
      #1;
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_q",    bus.q,          32'd0);
      checkOutput("rst_dz",   32'(bus.dz),   32'd0);
      checkOutput("rst_ovf",  32'(bus.ovf),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back directed vectors; each starts in the IDLE cycle right after done
      runCase("div3by2", 32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0);
      runCase("div1by3", 32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0);
      runCase("divzero", 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      runCase("overflow", 32'h00010000, 32'h00000001, ovfExpQ, 1'b0, 1'b1);
      runCase("div1by3b", 32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0);

      // Start while busy must be ignored: exactly one done with the first result
      bus.a     = 32'h00030000;
      bus.b     = 32'h00020000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      doneCount = 0;
      doneAt    = 0;
      qAtDone   = '0;
      for (int i = 2; i <= 70; i++) begin
         if (i == 10) begin
            bus.a     = 32'h00000000;
            bus.b     = 32'h00010000;
            bus.start = 1'b1;
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            doneCount++;
            if (doneCount == 1) begin
               doneAt  = i;
               qAtDone = bus.q;
            end
         end
      end
      checkOutput("busy_start_done_count", 32'(doneCount), 32'd1);
      checkOutput("busy_start_done_at",    32'(doneAt),    32'd49);
      checkOutput("busy_start_q",          qAtDone,        32'h00018000);

      // Reset in the middle of CALC aborts immediately with no done
      bus.a     = 32'h00030000;
      bus.b     = 32'h00020000;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("mid_rst_done", 32'(bus.done), 32'd0);
      checkOutput("mid_rst_q",    bus.q,          32'd0);
      checkOutput("mid_rst_dz",   32'(bus.dz),   32'd0);
      checkOutput("mid_rst_ovf",  32'(bus.ovf),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      doneCount = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) doneCount++;
      end
      checkOutput("mid_rst_no_done", 32'(doneCount), 32'd0);

      // Recovery after reset
      runCase("post_rst", 32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
